// File: rtl/vend_pkg.sv
// Shared types and constants for the vending coin controller.
// Coin values are in 5-unit steps; only 5 and 10 are legal.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } vend_state_e;

    localparam int COIN_W    = 5;
    localparam int COIN_UNIT = 5;
    localparam int COIN_5    = 5;
    localparam int COIN_10   = 10;

    function automatic logic coin_is_legal(input logic [COIN_W-1:0] value);
        return (value == COIN_W'(COIN_5)) || (value == COIN_W'(COIN_10));
    endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// Two-requester round-robin arbiter with combinational readys.
// The pointer only moves when both requesters contend and one is granted.
module vend_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic valid_a_i,
    input  logic valid_b_i,
    output logic ready_a_o,
    output logic ready_b_o
);

    logic ptr_q;
    logic ptr_d;
    logic contend;

    // ptr_q == 0 favours A on contention
    assign contend = enable_i & rst_n & valid_a_i & valid_b_i;
    assign ptr_d   = contend ? ~ptr_q : ptr_q;

    always_comb begin
        ready_a_o = 1'b0;
        ready_b_o = 1'b0;
        if (enable_i && rst_n) begin
            if (valid_a_i && valid_b_i) begin
                ready_a_o = ~ptr_q;
                ready_b_o = ptr_q;
            end else begin
                ready_a_o = valid_a_i;
                ready_b_o = valid_b_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vend_coin_controller.sv
// Vending sequencer: shared credit accumulator fed by two coin acceptors,
// vend/refund decision, 5-unit change pulse train and stock tracking.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no credit, accepting coins
//   COLLECT | partial credit, accepting coins, cancel refunds everything
//   VEND    | one-cycle dispense pulse, credit shows pre-vend value
//   CHANGE  | one change pulse per cycle until credit reaches zero
module vend_coin_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int CREDIT_W   = 6,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_a_valid,
    input  logic [COIN_W-1:0]   coin_a_val,
    output logic                coin_a_ready,
    input  logic                coin_b_valid,
    input  logic [COIN_W-1:0]   coin_b_val,
    output logic                coin_b_ready,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense,
    output logic                change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(COIN_UNIT);
    localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);

    vend_state_e         state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [STOCK_W-1:0]  stock_q;
    logic                dispense_q;
    logic                change_q;
    logic                reject_q;
    logic                busy_q;

    logic                sold_out_w;
    logic                accept_en;
    logic                hs_a;
    logic                hs_b;
    logic                hs_any;
    logic [COIN_W-1:0]   coin_sel;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] credit_after_vend;

    assign sold_out_w = (stock_q == '0);
    assign accept_en  = ((state_q == ST_IDLE) || (state_q == ST_COLLECT))
                        && !sold_out_w && !cancel;

    vend_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .enable_i  (accept_en),
        .valid_a_i (coin_a_valid),
        .valid_b_i (coin_b_valid),
        .ready_a_o (coin_a_ready),
        .ready_b_o (coin_b_ready)
    );

    assign hs_a   = coin_a_valid & coin_a_ready;
    assign hs_b   = coin_b_valid & coin_b_ready;
    assign hs_any = hs_a | hs_b;

    // Credit stays below PRICE while collecting, so the sum tops out at PRICE+5.
    assign coin_sel          = hs_a ? coin_a_val : coin_b_val;
    assign credit_sum        = credit_q + CREDIT_W'(coin_sel);
    assign credit_after_vend = credit_q - PRICE_C;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dispense_q <= 1'b0;
            reject_q   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (hs_any) begin
                        if (coin_is_legal(coin_sel)) begin
                            credit_q <= credit_sum;
                            if (credit_sum >= PRICE_C) begin
                                state_q    <= ST_VEND;
                                dispense_q <= 1'b1;
                                busy_q     <= 1'b1;
                            end else begin
                                state_q <= ST_COLLECT;
                            end
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end else if ((state_q == ST_COLLECT) && cancel) begin
                        state_q  <= ST_CHANGE;
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_VEND: begin
                    credit_q <= credit_after_vend;
                    if (credit_after_vend != '0) begin
                        state_q  <= ST_CHANGE;
                        change_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    if (credit_q > UNIT_C) begin
                        credit_q <= credit_q - UNIT_C;
                    end else begin
                        credit_q <= '0;
                        state_q  <= ST_IDLE;
                        change_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    credit_q <= '0;
                    change_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Restock overrides the vend decrement; VEND is unreachable at zero stock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stock_q <= STOCK_C;
        end else if (restock) begin
            stock_q <= STOCK_C;
        end else if ((state_q == ST_VEND) && !sold_out_w) begin
            stock_q <= stock_q - 1'b1;
        end
    end

    assign dispense    = dispense_q;
    assign change      = change_q;
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign sold_out    = sold_out_w;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_coin_controller.sv
// Scoreboard bench for vend_coin_controller: stimulus queues expected events,
// a negedge monitor pops and compares each handshake/dispense/change/reject.
module tb_vend_coin_controller;

    localparam int EV_HSA  = 0;
    localparam int EV_HSB  = 1;
    localparam int EV_DISP = 2;
    localparam int EV_CHG  = 3;
    localparam int EV_REJ  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_a_valid, coin_b_valid;
    logic [4:0] coin_a_val, coin_b_val;
    logic       coin_a_ready, coin_b_ready;
    logic       cancel, restock;
    logic       dispense, change, coin_reject, sold_out, busy;
    logic [5:0] credit;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    vend_coin_controller #(
        .PRICE(15), .CREDIT_W(6), .STOCK_W(4), .STOCK_INIT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_a_valid (coin_a_valid),
        .coin_a_val   (coin_a_val),
        .coin_a_ready (coin_a_ready),
        .coin_b_valid (coin_b_valid),
        .coin_b_val   (coin_b_val),
        .coin_b_ready (coin_b_ready),
        .cancel       (cancel),
        .restock      (restock),
        .dispense     (dispense),
        .change       (change),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .sold_out     (sold_out),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int data);
        ev_t e;
        e.kind = kind[2:0];
        e.data = data[7:0];
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected kind=%0d data=%0d", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind[2:0] || e.data !== data) begin
                bad++;
                $display("FAIL event: got kind=%0d data=%0d want kind=%0d data=%0d",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("one_ready", 32'(coin_a_ready & coin_b_ready), 0);
            if (coin_a_valid && coin_a_ready) observe(EV_HSA, 8'(coin_a_val));
            if (coin_b_valid && coin_b_ready) observe(EV_HSB, 8'(coin_b_val));
            if (dispense)    observe(EV_DISP, 8'(credit));
            if (change)      observe(EV_CHG, 8'(credit));
            if (coin_reject) observe(EV_REJ, 8'(credit));
        end
    end

    task automatic coin(input bit side_b, input int v);
        bit got;
        got = 1'b0;
        push(side_b ? EV_HSB : EV_HSA, v);
        if (side_b) begin
            coin_b_valid = 1'b1;
            coin_b_val   = v[4:0];
        end else begin
            coin_a_valid = 1'b1;
            coin_a_val   = v[4:0];
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = side_b ? coin_b_ready : coin_a_ready;
        end
        @(posedge clk);
        #1;
        if (side_b) coin_b_valid = 1'b0;
        else        coin_a_valid = 1'b0;
        chk("coin_handshake", 32'(got), 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        coin_a_valid = 1'b1; coin_a_val = 5'd5;
        coin_b_valid = 1'b1; coin_b_val = 5'd5;
        cancel = 1'b0; restock = 1'b0;
        #12;
        chk("rst_ready_a", 32'(coin_a_ready), 0);
        chk("rst_ready_b", 32'(coin_b_ready), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_change", 32'(change), 0);
        chk("rst_sold_out", 32'(sold_out), 0);
        coin_a_valid = 1'b0;
        coin_b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // exact price 5+5+5
        coin(0, 5);  chk("exact_credit1", 32'(credit), 5);
        coin(0, 5);  chk("exact_credit2", 32'(credit), 10);
        coin(0, 5);  chk("exact_credit3", 32'(credit), 15);
        chk("exact_dispense", 32'(dispense), 1);
        push(EV_DISP, 15);
        drain("exact_drain");
        chk("exact_credit_end", 32'(credit), 0);
        chk("exact_busy_end", 32'(busy), 0);

        // overpay 10+10: one change pulse
        coin(0, 10);
        coin(0, 10);
        chk("over_credit", 32'(credit), 20);
        push(EV_DISP, 20);
        push(EV_CHG, 5);
        drain("over_drain");
        chk("over_credit_end", 32'(credit), 0);

        // arbitration: both valid from IDLE
        push(EV_HSA, 5); push(EV_HSB, 5); push(EV_HSA, 5); push(EV_DISP, 15);
        coin_a_valid = 1'b1; coin_a_val = 5'd5;
        coin_b_valid = 1'b1; coin_b_val = 5'd5;
        @(negedge clk);
        chk("arb1_a", 32'(coin_a_ready), 1); chk("arb1_b", 32'(coin_b_ready), 0);
        @(negedge clk);
        chk("arb2_a", 32'(coin_a_ready), 0); chk("arb2_b", 32'(coin_b_ready), 1);
        @(negedge clk);
        chk("arb3_a", 32'(coin_a_ready), 1); chk("arb3_b", 32'(coin_b_ready), 0);
        @(posedge clk);
        #1;
        coin_a_valid = 1'b0;
        coin_b_valid = 1'b0;
        drain("arb_drain");
        chk("arb_sold_out", 32'(sold_out), 0);

        // cancel after 10: two refund pulses, coin blocked
        coin(0, 10);
        push(EV_CHG, 10);
        push(EV_CHG, 5);
        cancel = 1'b1;
        coin_a_valid = 1'b1; coin_a_val = 5'd5;
        @(negedge clk);
        chk("cancel_ready", 32'(coin_a_ready), 0);
        chk("cancel_busy_pre", 32'(busy), 0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        coin_a_valid = 1'b0;
        chk("cancel_busy", 32'(busy), 1);
        chk("cancel_dispense", 32'(dispense), 0);
        drain("cancel_drain");
        chk("cancel_credit_end", 32'(credit), 0);
        chk("cancel_stock_kept", 32'(sold_out), 0);

        // last item: B 5 then A 10 empties stock
        coin(1, 5);
        coin(0, 10);
        push(EV_DISP, 15);
        drain("last_drain");
        chk("sold_out_set", 32'(sold_out), 1);
        coin_a_valid = 1'b1; coin_a_val = 5'd5;
        coin_b_valid = 1'b1; coin_b_val = 5'd5;
        @(negedge clk);
        chk("sold_ready_a", 32'(coin_a_ready), 0);
        chk("sold_ready_b", 32'(coin_b_ready), 0);
        @(posedge clk);
        #1;
        coin_b_valid = 1'b0;
        restock = 1'b1;
        push(EV_HSA, 5);
        @(posedge clk);
        #1;
        restock = 1'b0;
        chk("restock_sold_out", 32'(sold_out), 0);
        @(negedge clk);
        chk("restock_ready_a", 32'(coin_a_ready), 1);
        @(posedge clk);
        #1;
        coin_a_valid = 1'b0;
        chk("restock_credit", 32'(credit), 5);
        coin(0, 10);
        push(EV_DISP, 15);
        drain("restock_drain");

        // illegal coin swallowed
        coin(1, 7);
        chk("reject_pulse", 32'(coin_reject), 1);
        push(EV_REJ, 0);
        drain("reject_drain");
        chk("reject_credit", 32'(credit), 0);
        chk("reject_busy", 32'(busy), 0);

        // reset during CHANGE
        coin(0, 10);
        coin(0, 10);
        push(EV_DISP, 20);
        @(posedge clk);
        #1;
        chk("mid_change", 32'(change), 1);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_change", 32'(change), 0);
        chk("rst_mid_credit", 32'(credit), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_change", 32'(change), 0);
        chk("post_rst_credit", 32'(credit), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
